// File: rtl/multiword_adder_pkg.sv
// Shared types and defaults for the multi-cycle chunked wide adder.
package multiword_adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int CHUNK_WIDTH_DEF = 8;
   localparam int NUM_CHUNKS_DEF  = 4;
   localparam int IDX_WIDTH_DEF   = $clog2(NUM_CHUNKS_DEF);

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multiword_chunk_adder_chunk.sv
// One-bit full adder cell and the ripple-carry chunk adder built from it.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module chunk_adder #(
   parameter int CHUNK_WIDTH = 8
) (
   input  logic [CHUNK_WIDTH-1:0] a,
   input  logic [CHUNK_WIDTH-1:0] b,
   input  logic                   cin,
   output logic [CHUNK_WIDTH-1:0] sum,
   output logic                   cout
);

   logic [CHUNK_WIDTH:0] carry;

   assign carry[0] = cin;
   assign cout     = carry[CHUNK_WIDTH];

   for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .sum  (sum[i]),
         .cout (carry[i+1])
      );
   end

endmodule

// File: rtl/multiword_chunk_adder.sv
// Wide unsigned adder: one chunk per cycle, LSB chunk first,
// carry registered between cycles, result held until handshaken.
module multiword_chunk_adder
   import multiword_adder_pkg::*;
#(
   parameter int CHUNK_WIDTH = CHUNK_WIDTH_DEF,
   parameter int NUM_CHUNKS  = NUM_CHUNKS_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] in_a,
   input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] in_b,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [CHUNK_WIDTH*NUM_CHUNKS:0]   out_sum,
   output logic                              busy
);

   localparam int TOTAL_WIDTH = CHUNK_WIDTH * NUM_CHUNKS;
   localparam int IDX_W       = idx_width(NUM_CHUNKS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CHUNKS - 1);

   state_t                 state_q;
   state_t                 state_d;
   logic [TOTAL_WIDTH-1:0] a_q;
   logic [TOTAL_WIDTH-1:0] b_q;
   logic                   carry_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   last;
   logic [CHUNK_WIDTH-1:0] a_chunk;
   logic [CHUNK_WIDTH-1:0] b_chunk;
   logic [CHUNK_WIDTH-1:0] chunk_sum;
   logic                   chunk_cout;

   assign a_chunk = a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
   assign b_chunk = b_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];

   chunk_adder #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
   ) u_chunk (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_q),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (last)     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE) & ~rst;
      busy     = (state_q != IDLE);
      last     = (idx_q == LAST);
   end

   // Operand registers need no reset; they are reloaded on every accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         carry_q   <= 1'b0;
         idx_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  out_sum <= '0;
                  carry_q <= 1'b0;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               out_sum[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] <= chunk_sum;
               carry_q <= chunk_cout;
               if (last) begin
                  out_sum[TOTAL_WIDTH] <= chunk_cout;
                  out_valid            <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_sum   <= '0;
               end
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_chunk_adder.sv
// Scoreboard bench for multiword_chunk_adder (8x4 default).
module tb_multiword_chunk_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [32:0] out_sum;
   logic        busy;

   int checks;
   int errors;
   logic [32:0] q[$];

   multiword_chunk_adder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .busy      (busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a pair, waits (bounded) for acceptance, records expectation.
   task automatic accept(input logic [31:0] a, input logic [31:0] b);
      int n;
      in_a = a;
      in_b = b;
      in_valid = 1;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      q.push_back({1'b0, a} + {1'b0, b});
      step();
      in_valid = 0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1;
      in_valid = 1;
      in_a = 32'h1;
      in_b = 32'h1;
      out_ready = 1;
      step();
      step();
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL rst_with_valid in_ready=%b busy=%b exp 0 0", in_ready, busy);
         errors++;
      end
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 33'h0) begin
         $display("FAIL reset_out valid=%b sum=%h exp 0 0", out_valid, out_sum);
         errors++;
      end
      in_valid = 0;
      rst = 0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_ready got %b exp 1", in_ready);
         errors++;
      end
   endtask

   task automatic test_single_carry();
      int n;
      logic [32:0] exp;
      bit ready_bad;
      out_ready = 1;
      accept(32'h0000_00FF, 32'h0000_0001);
      n = 0;
      ready_bad = 0;
      while (!out_valid && n < 20) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) ready_bad = 1;
         step();
         n++;
      end
      checks++;
      if (n != 4) begin
         $display("FAIL latency got %0d exp 4", n);
         errors++;
      end
      checks++;
      if (ready_bad || in_ready !== 1'b0) begin
         $display("FAIL ready_in_run got %b exp 0", in_ready);
         errors++;
      end
      exp = q.pop_front();
      checks++;
      if (out_sum !== exp) begin
         $display("FAIL single_carry got %h exp %h", out_sum, exp);
         errors++;
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 33'h0 || in_ready !== 1'b1) begin
         $display("FAIL after_handshake valid=%b sum=%h rdy=%b exp 0 0 1",
                  out_valid, out_sum, in_ready);
         errors++;
      end
   endtask

   task automatic test_full_ripple();
      int n;
      logic [32:0] exp;
      logic [31:0] av[2];
      logic [31:0] bv[2];
      av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0000_0001;
      av[1] = 32'hFFFF_FFFF; bv[1] = 32'hFFFF_FFFF;
      out_ready = 1;
      for (int i = 0; i < 2; i++) begin
         accept(av[i], bv[i]);
         wait_valid(n);
         exp = q.pop_front();
         checks++;
         if (n != 4 || out_sum !== exp) begin
            $display("FAIL ripple%0d got %h lat %0d exp %h lat 4", i, out_sum, n, exp);
            errors++;
         end
         step();
      end
   endtask

   task automatic test_mixed();
      int n;
      logic [32:0] exp;
      out_ready = 1;
      accept(32'h1234_5678, 32'h8765_4321);
      in_a = $urandom;
      in_b = $urandom;
      step();
      in_a = 32'hFFFF_FFFF;
      in_b = 32'hFFFF_FFFF;
      wait_valid(n);
      exp = q.pop_front();
      checks++;
      if (out_sum !== exp || out_sum !== 33'h0_9999_9999) begin
         $display("FAIL mixed got %h exp %h", out_sum, exp);
         errors++;
      end
      step();
   endtask

   task automatic test_backpressure();
      int n;
      logic [32:0] exp;
      bit bad;
      out_ready = 0;
      accept(32'h1234_5678, 32'h8765_4321);
      wait_valid(n);
      exp = q.pop_front();
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (out_valid !== 1'b1 || out_sum !== exp || in_ready !== 1'b0 || busy !== 1'b1)
            bad = 1;
         step();
      end
      checks++;
      if (bad || out_valid !== 1'b1 || out_sum !== exp) begin
         $display("FAIL backpressure got v=%b %h exp v=1 %h", out_valid, out_sum, exp);
         errors++;
      end
      out_ready = 1;
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL bp_release v=%b rdy=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [32:0] exp;
      out_ready = 1;
      accept(32'hFFFF_FFFF, 32'h0000_0001);
      step();
      rst = 1;
      step();
      rst = 0;
      q.delete();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 33'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL reset_mid v=%b sum=%h busy=%b rdy=%b exp 0 0 0 1",
                  out_valid, out_sum, busy, in_ready);
         errors++;
      end
      accept(32'd5, 32'd7);
      wait_valid(n);
      exp = q.pop_front();
      checks++;
      if (n != 4 || out_sum !== exp || out_sum !== 33'h0_0000_000C) begin
         $display("FAIL post_reset got %h lat %0d exp %h lat 4", out_sum, n, exp);
         errors++;
      end
      step();
   endtask

   task automatic test_back_to_back();
      int nacc;
      int npop;
      int pop1;
      int acc2;
      bit took;
      logic [32:0] exp;
      nacc = 0;
      npop = 0;
      pop1 = -1;
      acc2 = -1;
      out_ready = 1;
      in_a = 32'd1;
      in_b = 32'd2;
      in_valid = 1;
      for (int c = 0; c < 40 && npop < 2; c++) begin
         took = 0;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               $display("FAIL b2b_spurious got %h exp none", out_sum);
               errors++;
            end else begin
               exp = q.pop_front();
               if (out_sum !== exp) begin
                  $display("FAIL b2b_result%0d got %h exp %h", npop, out_sum, exp);
                  errors++;
               end
            end
            npop++;
            if (npop == 1) pop1 = c;
         end
         if (in_valid && in_ready) begin
            q.push_back({1'b0, in_a} + {1'b0, in_b});
            nacc++;
            took = 1;
            if (nacc == 2) acc2 = c;
         end
         step();
         if (took) begin
            if (nacc == 1) begin
               in_a = 32'd3;
               in_b = 32'd4;
            end else begin
               in_valid = 0;
            end
         end
      end
      in_valid = 0;
      checks++;
      if (nacc != 2 || npop != 2 || acc2 <= pop1) begin
         $display("FAIL b2b_order acc=%0d pop=%0d acc2=%0d pop1=%0d exp 2 2 acc2>pop1",
                  nacc, npop, acc2, pop1);
         errors++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1;
      in_valid = 0;
      in_a = '0;
      in_b = '0;
      out_ready = 0;
      test_reset();
      test_single_carry();
      test_full_ripple();
      test_mixed();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
